// File: rtl/pillar_scroller_if.sv
// Pillar/gap bus between the scroller and its consumers (collision detection, scoreboard).
// The slave side is the scroller itself; the master side drives tick, fail, restart and random input.
interface pillar_scroller_if;
    logic       game_reset;
    logic       enable;
    logic       fail;
    logic [3:0] rand_in;
    logic [7:0] pillar_1_x;
    logic [7:0] pillar_2_x;
    logic [7:0] pillar_3_x;
    logic [6:0] gap_1_y;
    logic [6:0] gap_2_y;
    logic [6:0] gap_3_y;
    logic       pass_pulse;
    logic       running;

    modport master (
        output game_reset, enable, fail, rand_in,
        input  pillar_1_x, pillar_2_x, pillar_3_x,
        input  gap_1_y, gap_2_y, gap_3_y,
        input  pass_pulse, running
    );

    modport slave (
        input  game_reset, enable, fail, rand_in,
        output pillar_1_x, pillar_2_x, pillar_3_x,
        output gap_1_y, gap_2_y, gap_3_y,
        output pass_pulse, running
    );
endinterface

// File: rtl/pillar_scroller.sv
// Three round-robin scrolling pillars with random gaps, frozen by fail until restart.
// Optional macro SPEEDUP_EN: step grows 1->2->3 px per tick after every 8 launches.
module pillar_scroller #(
    parameter logic [7:0] SPAWN_X  = 8'd191,
    parameter logic [7:0] SPACING  = 8'd64,
    parameter logic [6:0] GAP_MIN  = 7'd8,
    parameter logic [6:0] GAP_STEP = 7'd4,
    parameter logic [7:0] BIRD_X   = 8'd14
) (
    input  logic             clk,
    input  logic             reset_n,
    pillar_scroller_if.slave ps
);
    localparam logic [7:0] LAUNCH_MAX = SPAWN_X - SPACING;
    localparam logic [1:0] IDX_NONE   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} state_t;

    state_t     r_state;
    logic [7:0] r_x   [3];
    logic [6:0] r_gap [3];
    logic [1:0] r_next;
    logic [1:0] r_last;
    logic       r_pass;
    logic       r_running;

    logic [1:0] w_step;
`ifdef SPEEDUP_EN
    logic [2:0] r_launch_cnt;
    logic [1:0] r_step;
    assign w_step = r_step;
`else
    assign w_step = 2'd1;
`endif

    logic       w_tick;
    logic       w_launch;
    logic       w_last_clear;
    logic [7:0] w_next_x;
    logic [7:0] w_last_x;
    logic [6:0] w_gap_new;
    logic [7:0] w_x_next [3];
    logic [2:0] w_cross;

    assign w_tick    = ps.enable && !ps.fail && (r_state != S_FROZEN);
    assign w_gap_new = GAP_MIN + 7'(ps.rand_in) * GAP_STEP;

    always_comb begin
        w_next_x = 8'd0;
        w_last_x = 8'd0;
        for (int i = 0; i < 3; i++) begin
            if (r_next == 2'(i)) w_next_x = r_x[i];
            if (r_last == 2'(i)) w_last_x = r_x[i];
        end
        w_last_clear = (r_last == IDX_NONE) || (w_last_x <= LAUNCH_MAX) || (w_last_x == 8'd0);
        w_launch     = (w_next_x == 8'd0) && w_last_clear;
        // Launched pillar holds SPAWN_X this tick; others step down saturating at 0
        for (int i = 0; i < 3; i++) begin
            if (w_launch && r_next == 2'(i))
                w_x_next[i] = SPAWN_X;
            else if (r_x[i] <= {6'd0, w_step})
                w_x_next[i] = 8'd0;
            else
                w_x_next[i] = r_x[i] - {6'd0, w_step};
            w_cross[i] = (r_x[i] > BIRD_X) && (w_x_next[i] <= BIRD_X);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !ps.game_reset) begin
            r_state   <= S_IDLE;
            r_next    <= 2'd0;
            r_last    <= IDX_NONE;
            r_pass    <= 1'b0;
            r_running <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_x[i]   <= 8'd0;
                r_gap[i] <= GAP_MIN;
            end
`ifdef SPEEDUP_EN
            r_launch_cnt <= 3'd0;
            r_step       <= 2'd1;
`endif
        end else begin
            r_pass <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ps.enable && !ps.fail) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (ps.fail) begin
                        r_state   <= S_FROZEN;
                        r_running <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (w_tick) begin
                r_pass <= |w_cross;
                for (int i = 0; i < 3; i++) begin
                    r_x[i] <= w_x_next[i];
                    if (w_launch && r_next == 2'(i)) r_gap[i] <= w_gap_new;
                end
                if (w_launch) begin
                    r_last <= r_next;
                    r_next <= (r_next == 2'd2) ? 2'd0 : r_next + 2'd1;
`ifdef SPEEDUP_EN
                    // Step rises each time the 3-bit counter wraps, capped at 3
                    r_launch_cnt <= r_launch_cnt + 3'd1;
                    if (r_launch_cnt == 3'd7 && r_step != 2'd3) r_step <= r_step + 2'd1;
`endif
                end
            end
        end
    end

    assign ps.pillar_1_x = r_x[0];
    assign ps.pillar_2_x = r_x[1];
    assign ps.pillar_3_x = r_x[2];
    assign ps.gap_1_y    = r_gap[0];
    assign ps.gap_2_y    = r_gap[1];
    assign ps.gap_3_y    = r_gap[2];
    assign ps.pass_pulse = r_pass;
    assign ps.running    = r_running;
endmodule

// File: tb/tb_pillar_scroller.sv
// Scoreboard bench for pillar_scroller: a behavioural model queues the expected outputs per cycle.
module tb_pillar_scroller;
    localparam int SPAWN_X  = 191;
    localparam int SPACING  = 64;
    localparam int GAP_MIN  = 8;
    localparam int GAP_STEP = 4;
    localparam int BIRD_X   = 14;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pillar_scroller_if ps_if ();

    pillar_scroller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ps      (ps_if)
    );

    typedef struct packed {
        logic [7:0] x1, x2, x3;
        logic [6:0] g1, g2, g3;
        logic       pass;
        logic       run;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    int m_x[3];
    int m_gap[3];
    int m_next, m_last, m_state, m_launches;
    bit m_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int cur_step();
`ifdef SPEEDUP_EN
        if (m_launches >= 16) return 3;
        if (m_launches >= 8) return 2;
`endif
        return 1;
    endfunction

    task automatic model_update(input bit rn, input bit gr, input bit en, input bit fl, input int rnd);
        int nx[3];
        int st;
        bit launch;
        m_pass = 1'b0;
        if (!rn || !gr) begin
            for (int i = 0; i < 3; i++) begin
                m_x[i]   = 0;
                m_gap[i] = GAP_MIN;
            end
            m_next = 0; m_last = -1; m_state = 0; m_launches = 0;
            return;
        end
        if (m_state == 2) return;
        if (m_state == 1 && fl) begin
            m_state = 2;
            return;
        end
        if (!en || fl) return;
        m_state = 1;
        st = cur_step();
        launch = (m_x[m_next] == 0) &&
                 (m_last < 0 || m_x[m_last] <= SPAWN_X - SPACING || m_x[m_last] == 0);
        for (int i = 0; i < 3; i++) begin
            if (launch && i == m_next) nx[i] = SPAWN_X;
            else if (m_x[i] < st)      nx[i] = 0;
            else                       nx[i] = m_x[i] - st;
            if (m_x[i] > BIRD_X && nx[i] <= BIRD_X) m_pass = 1'b1;
        end
        if (launch) begin
            m_gap[m_next] = GAP_MIN + rnd * GAP_STEP;
            m_last = m_next;
            m_next = (m_next + 1) % 3;
            m_launches++;
        end
        for (int i = 0; i < 3; i++) m_x[i] = nx[i];
    endtask

    task automatic cycle(input bit rn, input bit gr, input bit en, input bit fl, input logic [3:0] rnd);
        exp_t e;
        reset_n          = rn;
        ps_if.game_reset = gr;
        ps_if.enable     = en;
        ps_if.fail       = fl;
        ps_if.rand_in    = rnd;
        model_update(rn, gr, en, fl, int'(rnd));
        e.x1 = 8'(m_x[0]);   e.x2 = 8'(m_x[1]);   e.x3 = 8'(m_x[2]);
        e.g1 = 7'(m_gap[0]); e.g2 = 7'(m_gap[1]); e.g3 = 7'(m_gap[2]);
        e.pass = m_pass;
        e.run  = (m_state == 1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("pillar_x", {8'd0, ps_if.pillar_1_x, ps_if.pillar_2_x, ps_if.pillar_3_x}, {8'd0, e.x1, e.x2, e.x3});
            check("gap_y", {11'd0, ps_if.gap_1_y, ps_if.gap_2_y, ps_if.gap_3_y}, {11'd0, e.g1, e.g2, e.g3});
            check("pass_pulse", {31'd0, ps_if.pass_pulse}, {31'd0, e.pass});
            check("running", {31'd0, ps_if.running}, {31'd0, e.run});
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'($urandom_range(15)));
    endtask

    initial begin
        reset_n          = 1'b0;
        ps_if.game_reset = 1'b1;
        ps_if.enable     = 1'b0;
        ps_if.fail       = 1'b0;
        ps_if.rand_in    = 4'd0;

        // Reset, then idle cycles with no tick
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("rst_x1", {24'd0, ps_if.pillar_1_x}, 32'd0);
        check("rst_g1", {25'd0, ps_if.gap_1_y}, 32'd8);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd9);

        // First tick launches pillar 1 with gap 8+5*4
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd5);
        check("t1_x1", {24'd0, ps_if.pillar_1_x}, 32'd191);
        check("t1_g1", {25'd0, ps_if.gap_1_y}, 32'd28);
        check("t1_x23", {16'd0, ps_if.pillar_2_x, ps_if.pillar_3_x}, 32'd0);
        check("t1_run", {31'd0, ps_if.running}, 32'd1);

        // Long continuous scroll: round-robin launches, parking, pass pulses
        ticks(420);

        // Enable low: nothing may move
        for (int k = 0; k < 50; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'($urandom_range(15)));

        // Sporadic ticks
        for (int k = 0; k < 200; k++)
            cycle(1'b1, 1'b1, 1'($urandom_range(1)), 1'b0, 4'($urandom_range(15)));

        // Restart, run until pillar 1 sits at 100, then freeze
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
        check("grst_run", {31'd0, ps_if.running}, 32'd0);
        for (int k = 0; k < 400 && m_x[0] != 100; k++) ticks(1);
        check("reach100", {24'd0, ps_if.pillar_1_x}, 32'd100);
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'($urandom_range(15)));
        check("frz_x1", {24'd0, ps_if.pillar_1_x}, 32'd100);
        check("frz_run", {31'd0, ps_if.running}, 32'd0);
        ticks(10);
        check("frz_hold", {24'd0, ps_if.pillar_1_x}, 32'd100);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("grst_x", {8'd0, ps_if.pillar_1_x, ps_if.pillar_2_x, ps_if.pillar_3_x}, 32'd0);
        ticks(5);
        // Fail while idle keeps it idle
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
        ticks(150);

        // Reset mid-run
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
        check("mrst_x", {8'd0, ps_if.pillar_1_x, ps_if.pillar_2_x, ps_if.pillar_3_x}, 32'd0);
        check("mrst_run", {31'd0, ps_if.running}, 32'd0);

        // Long run to exercise many launches (and larger steps when enabled)
        ticks(1400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
